// File: rtl/button_conditioner.sv
// Push-button front end for the LIGHTS colour cycler: synchronise, debounce,
// and emit one advance pulse per press plus auto-repeat pulses while held.
module button_conditioner #(
  parameter int unsigned DEBOUNCE_CYCLES = 4,
  parameter int unsigned HOLD_CYCLES     = 16,
  parameter int unsigned REPEAT_CYCLES   = 8,
  parameter bit          REPEAT_EN       = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_raw,
  output logic button,
  output logic btn_level,
  output logic held
);

  localparam logic [15:0] DB_LAST   = 16'(DEBOUNCE_CYCLES - 1);
  localparam logic [15:0] HOLD_LAST = 16'(HOLD_CYCLES - 1);
  localparam logic [15:0] RPT_LAST  = 16'(REPEAT_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_PRESSED = 2'd1,
    ST_REPEAT  = 2'd2
  } state_e;

  logic        s1_q;
  logic        s_q;
  logic        level_q;
  logic        level_d;
  logic [15:0] dcnt_q;
  logic [15:0] dcnt_d;
  logic        rise_s;
  logic        fall_s;
  state_e      state_q;
  logic [15:0] hcnt_q;
  logic        button_q;
  logic        held_q;

  // Two-flop synchroniser for the asynchronous pin
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q <= 1'b0;
      s_q  <= 1'b0;
    end else begin
      s1_q <= btn_raw;
      s_q  <= s1_q;
    end
  end

  // A new level is accepted only after DEBOUNCE_CYCLES consecutive differing samples
  always_comb begin
    dcnt_d  = 16'd0;
    level_d = level_q;
    rise_s  = 1'b0;
    fall_s  = 1'b0;
    if (s_q != level_q) begin
      if (dcnt_q == DB_LAST) begin
        level_d = ~level_q;
        dcnt_d  = 16'd0;
        rise_s  = s_q;
        fall_s  = ~s_q;
      end else begin
        dcnt_d  = dcnt_q + 16'd1;
      end
    end else begin
      dcnt_d = 16'd0;
    end
  end

  // Debounce state registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dcnt_q  <= 16'd0;
      level_q <= 1'b0;
    end else begin
      dcnt_q  <= dcnt_d;
      level_q <= level_d;
    end
  end

  // Press / auto-repeat FSM; a release always takes priority over a due repeat
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      hcnt_q   <= 16'd0;
      button_q <= 1'b0;
      held_q   <= 1'b0;
    end else begin
      button_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          held_q <= 1'b0;
          hcnt_q <= 16'd0;
          if (rise_s) begin
            state_q  <= ST_PRESSED;
            button_q <= 1'b1;
          end else begin
            state_q  <= ST_IDLE;
          end
        end
        ST_PRESSED: begin
          if (fall_s) begin
            state_q <= ST_IDLE;
            hcnt_q  <= 16'd0;
            held_q  <= 1'b0;
          end else if (hcnt_q == HOLD_LAST) begin
            state_q  <= ST_REPEAT;
            hcnt_q   <= 16'd0;
            held_q   <= 1'b1;
            button_q <= REPEAT_EN;
          end else begin
            hcnt_q <= hcnt_q + 16'd1;
          end
        end
        ST_REPEAT: begin
          if (fall_s) begin
            state_q <= ST_IDLE;
            hcnt_q  <= 16'd0;
            held_q  <= 1'b0;
          end else if (REPEAT_EN && (hcnt_q == RPT_LAST)) begin
            button_q <= 1'b1;
            hcnt_q   <= 16'd0;
          end else begin
            hcnt_q <= hcnt_q + 16'd1;
          end
        end
        default: begin
          state_q <= ST_IDLE;
          hcnt_q  <= 16'd0;
          held_q  <= 1'b0;
        end
      endcase
    end
  end

  assign button    = button_q;
  assign btn_level = level_q;
  assign held      = held_q;

endmodule
